// File: rtl/text_overlay_typewriter.sv
// Text overlay generator: loadable 4-bit character buffer rendered through a
// 5x7 glyph ROM at a fixed screen position, with an optional typewriter reveal
// (one character every FRAMES_PER_CHAR frames) and a blinking block cursor.
// draw/rgb are registered one cycle after the x/y/active inputs.
module text_overlay_typewriter #(
   parameter int         NUM_CHARS       = 12,
   parameter int         SCALE_LOG2      = 1,
   parameter int         TEXT_X0         = 248,
   parameter int         TEXT_Y0         = 325,
   parameter int         FRAMES_PER_CHAR = 4,
   parameter int         BLINK_FRAMES    = 16,
   parameter logic [5:0] COLOR           = 6'b110110
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic       active,
   input  logic       frame_start,
   input  logic       tw_en,
   input  logic       tw_restart,
   input  logic       wr_en,
   input  logic [3:0] wr_addr,
   input  logic [3:0] wr_code,
   output logic       draw,
   output logic [5:0] rgb,
   output logic       tw_done
);

   localparam int FW = (FRAMES_PER_CHAR > 1) ? $clog2(FRAMES_PER_CHAR) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [3:0] CURSOR_CODE = 4'd15;

   typedef enum logic [1:0] {SHOW, TYPE, DONE} state_t;

   // Power-on message "WATERLOO ENG"; slots past the message stay blank.
   function automatic logic [3:0] init_code(input int i);
      logic [3:0] c;
      case (i)
         0: c = 4'd1;   1: c = 4'd2;   2: c = 4'd3;   3: c = 4'd4;
         4: c = 4'd5;   5: c = 4'd6;   6: c = 4'd7;   7: c = 4'd7;
         8: c = 4'd0;   9: c = 4'd4;  10: c = 4'd8;  11: c = 4'd9;
         default: c = 4'd0;
      endcase
      return (i < NUM_CHARS) ? c : 4'd0;
   endfunction

   // 5x7 glyph ROM; row 0 sits in the top five bits, MSB is the leftmost column.
   function automatic logic [4:0] glyph_row(input logic [3:0] code, input logic [2:0] r);
      logic [34:0] g;
      int          base;
      case (code)
         4'd1:    g = {5'h11, 5'h11, 5'h11, 5'h15, 5'h15, 5'h1B, 5'h11};
         4'd2:    g = {5'h0E, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
         4'd3:    g = {5'h1F, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04};
         4'd4:    g = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
         4'd5:    g = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h14, 5'h12, 5'h11};
         4'd6:    g = {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F};
         4'd7:    g = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
         4'd8:    g = {5'h11, 5'h19, 5'h15, 5'h15, 5'h13, 5'h11, 5'h11};
         4'd9:    g = {5'h0E, 5'h11, 5'h10, 5'h17, 5'h11, 5'h11, 5'h0E};
         4'd15:   g = {7{5'h1F}};
         default: g = '0;
      endcase
      base = (6 - int'(r)) * 5;
      return (r > 3'd6) ? 5'h00 : g[base +: 5];
   endfunction

   logic [3:0]    buf_q [16];
   state_t        state_q;
   logic [4:0]    reveal_q;
   logic [FW-1:0] frame_q;
   logic          done_q;
   logic [BW-1:0] blink_cnt_q;
   logic          blink_q;
   logic          draw_q;
   logic [5:0]    rgb_q;

   logic [9:0] rel_x, rel_y, col, row, idx, gcol;
   logic       in_box, show_all;
   logic [3:0] code_d;
   logic [4:0] bits, shifted;
   logic       hit_d;

   // Character buffer: reset reloads the message, writes past NUM_CHARS are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) buf_q[i] <= init_code(i);
      end else if (wr_en && ({1'b0, wr_addr} < 5'(NUM_CHARS))) begin
         buf_q[wr_addr] <= wr_code;
      end
   end

   // Pixel hit test: map screen position to character cell and glyph bit.
   always_comb begin
      rel_x    = x - 10'(TEXT_X0);
      rel_y    = y - 10'(TEXT_Y0);
      col      = rel_x >> SCALE_LOG2;
      row      = rel_y >> SCALE_LOG2;
      idx      = col / 10'd6;
      gcol     = col % 10'd6;
      in_box   = (y >= 10'(TEXT_Y0)) && (row < 10'd7) &&
                 (x >= 10'(TEXT_X0)) && (idx < 10'(NUM_CHARS));
      show_all = !tw_en || (state_q != TYPE);
      code_d   = 4'd0;
      if (show_all || (idx < {5'd0, reveal_q})) begin
         code_d = buf_q[idx[3:0]];
      end else if (idx == {5'd0, reveal_q}) begin
         code_d = blink_q ? CURSOR_CODE : 4'd0;
      end
      bits    = glyph_row(code_d, row[2:0]);
      shifted = bits << gcol[2:0];
      hit_d   = active && in_box && (gcol < 10'd5) && shifted[4];
   end

   // Output register: one cycle of latency from the pixel coordinates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         draw_q <= 1'b0;
         rgb_q  <= 6'd0;
      end else begin
         draw_q <= hit_d;
         rgb_q  <= hit_d ? COLOR : 6'd0;
      end
   end

   // Typewriter FSM: a restart pulse beats a coincident frame_start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= SHOW;
         reveal_q <= 5'd0;
         frame_q  <= '0;
         done_q   <= 1'b0;
      end else if (tw_en && tw_restart) begin
         state_q  <= TYPE;
         reveal_q <= 5'd0;
         frame_q  <= '0;
         done_q   <= 1'b0;
      end else if (frame_start) begin
         if (!tw_en) begin
            state_q <= SHOW;
            done_q  <= 1'b0;
         end else begin
            case (state_q)
               SHOW: begin
                  state_q  <= TYPE;
                  reveal_q <= 5'd0;
                  frame_q  <= '0;
               end
               TYPE: begin
                  if (frame_q == FW'(FRAMES_PER_CHAR - 1)) begin
                     frame_q  <= '0;
                     reveal_q <= reveal_q + 5'd1;
                     if (reveal_q + 5'd1 == 5'(NUM_CHARS)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end
                  end else begin
                     frame_q <= frame_q + 1'b1;
                  end
               end
               DONE:    done_q  <= 1'b1;
               default: state_q <= SHOW;
            endcase
         end
      end
   end

   // Cursor blink: free-running over frame_start in every state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt_q <= '0;
         blink_q     <= 1'b1;
      end else if (frame_start) begin
         if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
         end
      end
   end

   assign draw    = draw_q;
   assign rgb     = rgb_q;
   assign tw_done = done_q;

endmodule
